// File: rtl/display_source_select.sv
// Selects one of four processor observation points for the 8-digit hex display,
// with synchronised/debounced "next" and "hold" buttons.
module display_source_select #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_next,
    input  logic        btn_hold,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_rdata,
    output logic [31:0] display_word,
    output logic [1:0]  sel,
    output logic        hold_active,
    output logic        sel_changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        LIVE = 1'b0,
        HOLD = 1'b1
    } hold_state_t;

    // Bit 0 carries the "next" button, bit 1 the "hold" button.
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       deb;
    logic [1:0]       deb_q;
    logic [CNT_W-1:0] cnt [2];

    logic             next_pulse;
    logic             hold_pulse;
    logic [31:0]      src_word;
    hold_state_t      state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1     <= '0;
            s2     <= '0;
            deb    <= '0;
            deb_q  <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            s1    <= {btn_hold, btn_next};
            s2    <= s1;
            deb_q <= deb;
            for (int b = 0; b < 2; b++) begin
                // A level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
                if (s2[b] == deb[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == CNT_MAX) begin
                    deb[b] <= s2[b];
                    cnt[b] <= '0;
                end else begin
                    cnt[b] <= cnt[b] + CNT_W'(1);
                end
            end
        end
    end

    assign next_pulse = deb[0] & ~deb_q[0];
    assign hold_pulse = deb[1] & ~deb_q[1];

    always_comb begin
        src_word = pc;
        case (sel)
            2'd0:    src_word = pc;
            2'd1:    src_word = instr;
            2'd2:    src_word = alu_result;
            default: src_word = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= LIVE;
            sel          <= 2'd0;
            sel_changed  <= 1'b0;
            hold_active  <= 1'b0;
            display_word <= '0;
        end else begin
            sel_changed <= next_pulse;
            if (next_pulse) begin
                sel <= sel + 2'd1;
            end
            case (state)
                LIVE: begin
                    display_word <= src_word;
                    if (hold_pulse) begin
                        state       <= HOLD;
                        hold_active <= 1'b1;
                    end
                end
                default: begin
                    // While frozen, a source change still takes one snapshot of the new source.
                    if (sel_changed) begin
                        display_word <= src_word;
                    end
                    if (hold_pulse) begin
                        state       <= LIVE;
                        hold_active <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_source_select.sv
// Scoreboard bench for display_source_select with a short debounce window.
module tb_display_source_select;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_next;
    logic        btn_hold;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [31:0] display_word;
    logic [1:0]  sel;
    logic        hold_active;
    logic        sel_changed;

    display_source_select #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_next     (btn_next),
        .btn_hold     (btn_hold),
        .pc           (pc),
        .instr        (instr),
        .alu_result   (alu_result),
        .mem_rdata    (mem_rdata),
        .display_word (display_word),
        .sel          (sel),
        .hold_active  (hold_active),
        .sel_changed  (sel_changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        string       tag;
        logic [31:0] word;
        logic [1:0]  sel;
        logic        hold;
        logic        chg;
        logic        chk_word;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [1:0]  cur_sel;
    logic        in_hold;
    logic [31:0] frozen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=0x%08h expected=0x%08h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] src(input logic [1:0] s);
        case (s)
            2'd0:    return pc;
            2'd1:    return instr;
            2'd2:    return alu_result;
            default: return mem_rdata;
        endcase
    endfunction

    task automatic push(input int k, input string tag, input logic [31:0] w, input logic [1:0] s,
                        input logic h, input logic c, input logic cw);
        exp_t e;
        int   pos;
        e.due = cyc + k;
        e.tag = tag;
        e.word = w;
        e.sel = s;
        e.hold = h;
        e.chg = c;
        e.chk_word = cw;
        pos = sbq.size();
        for (int i = 0; i < sbq.size(); i++) begin
            if (sbq[i].due > e.due) begin
                pos = i;
                break;
            end
        end
        sbq.insert(pos, e);
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            if (e.chk_word) check({e.tag, ".word"}, display_word, e.word);
            check({e.tag, ".sel"}, {30'd0, sel}, {30'd0, e.sel});
            check({e.tag, ".hold"}, {31'd0, hold_active}, {31'd0, e.hold});
            check({e.tag, ".chg"}, {31'd0, sel_changed}, {31'd0, e.chg});
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".word"}, display_word, 32'd0);
        check({tag, ".sel"}, {30'd0, sel}, 32'd0);
        check({tag, ".hold"}, {31'd0, hold_active}, 32'd0);
        check({tag, ".chg"}, {31'd0, sel_changed}, 32'd0);
    endtask

    task automatic step_next(input string tag);
        logic [1:0]  ns;
        logic [31:0] w_old;
        ns = cur_sel + 2'd1;
        w_old = in_hold ? frozen : src(cur_sel);
        btn_next = 1'b1;
        push(6,  {tag, "_pre"},  w_old,   cur_sel, in_hold, 1'b0, 1'b1);
        push(7,  {tag, "_step"}, w_old,   ns,      in_hold, 1'b1, 1'b1);
        push(8,  {tag, "_post"}, src(ns), ns,      in_hold, 1'b0, 1'b1);
        push(16, {tag, "_held"}, src(ns), ns,      in_hold, 1'b0, 1'b1);
        cur_sel = ns;
        if (in_hold) frozen = src(ns);
        wait_cycles(10);
        btn_next = 1'b0;
        wait_cycles(10);
    endtask

    task automatic press_hold(input string tag);
        logic [31:0] w_old;
        w_old = in_hold ? frozen : src(cur_sel);
        btn_hold = 1'b1;
        push(6, {tag, "_pre"},  w_old,        cur_sel, in_hold,  1'b0, 1'b1);
        push(7, {tag, "_edge"}, src(cur_sel), cur_sel, !in_hold, 1'b0, !in_hold);
        push(8, {tag, "_post"}, src(cur_sel), cur_sel, !in_hold, 1'b0, 1'b1);
        in_hold = !in_hold;
        frozen = src(cur_sel);
        wait_cycles(10);
        btn_hold = 1'b0;
        wait_cycles(10);
    endtask

    initial begin
        logic [1:0] ns;
        reset = 1'b1;
        btn_next = 1'b0;
        btn_hold = 1'b0;
        pc = 32'h0040_0000;
        instr = 32'h1111_1111;
        alu_result = 32'h0000_002A;
        mem_rdata = 32'h3333_3333;
        cur_sel = 2'd0;
        in_hold = 1'b0;
        frozen = 32'd0;

        wait_cycles(3);
        check_reset_outputs("in_reset");
        reset = 1'b0;
        push(1, "release", pc, 2'd0, 1'b0, 1'b0, 1'b1);
        push(2, "release2", pc, 2'd0, 1'b0, 1'b0, 1'b1);
        wait_cycles(4);

        // Bouncing press never survives the debounce window.
        for (int k = 1; k <= 14; k++) push(k, "bounce", pc, 2'd0, 1'b0, 1'b0, 1'b1);
        btn_next = 1'b1; wait_cycles(2);
        btn_next = 1'b0; wait_cycles(1);
        btn_next = 1'b1; wait_cycles(2);
        btn_next = 1'b0; wait_cycles(12);

        step_next("n1");
        step_next("n2");
        step_next("n3");
        step_next("wrap");
        step_next("n5");
        step_next("n6");

        // Freeze ALU result, then change it underneath.
        press_hold("hold_on");
        alu_result = 32'h0000_0055;
        push(2, "frozen_alu", 32'h0000_002A, cur_sel, 1'b1, 1'b0, 1'b1);
        wait_cycles(4);
        press_hold("hold_off");

        press_hold("hold_on2");
        mem_rdata = 32'hDEAD_BEEF;
        wait_cycles(2);
        step_next("hold_next");
        mem_rdata = 32'h1234_5678;
        push(2, "frozen_mem", 32'hDEAD_BEEF, 2'd3, 1'b1, 1'b0, 1'b1);
        wait_cycles(4);
        press_hold("hold_off2");

        // Simultaneous next and hold from LIVE.
        ns = cur_sel + 2'd1;
        btn_next = 1'b1;
        btn_hold = 1'b1;
        push(6, "both_pre",  src(cur_sel), cur_sel, 1'b0, 1'b0, 1'b1);
        push(7, "both_edge", src(cur_sel), ns,      1'b1, 1'b1, 1'b1);
        push(8, "both_post", src(ns),      ns,      1'b1, 1'b0, 1'b1);
        frozen = src(ns);
        cur_sel = ns;
        in_hold = 1'b1;
        wait_cycles(10);
        btn_next = 1'b0;
        btn_hold = 1'b0;
        pc = 32'h0040_0100;
        push(2, "both_frozen", frozen, cur_sel, 1'b1, 1'b0, 1'b1);
        wait_cycles(10);

        // Reset in the middle of a debounce count.
        btn_next = 1'b1;
        wait_cycles(4);
        reset = 1'b1;
        wait_cycles(1);
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        cur_sel = 2'd0;
        in_hold = 1'b0;
        push(1, "rst_live", pc,    2'd0, 1'b0, 1'b0, 1'b1);
        push(6, "rst_pre",  pc,    2'd0, 1'b0, 1'b0, 1'b1);
        push(7, "rst_step", pc,    2'd1, 1'b0, 1'b1, 1'b1);
        push(8, "rst_post", instr, 2'd1, 1'b0, 1'b0, 1'b1);
        wait_cycles(10);
        btn_next = 1'b0;
        wait_cycles(12);

        check("sb_drain", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
